// File: rtl/rs_cw_buffer_ctrl_if.sv
// rs_cw_buffer_ctrl_if: FIFO, producer, result and consumer handshakes of the codeword buffer controller
interface rs_cw_buffer_ctrl_if #(parameter int BEAT_W = 6, parameter int CNT_W = 3);
  logic              flush_i;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic              fifo_push;
  logic              fifo_full;
  logic              fifo_pull;
  logic              fifo_empty;
  logic              fifo_flush;
  logic              res_valid;
  logic              res_ready;
  logic              out_valid;
  logic              out_ready;
  logic              out_sop;
  logic              out_eop;
  logic [BEAT_W-1:0] out_beat_idx;
  logic [CNT_W-1:0]  cw_stored;
  logic              err_overflow;
  logic              err_framing;
  logic              err_underflow;
  logic [15:0]       cw_in_cnt;
  logic [15:0]       cw_out_cnt;
  modport master (
    output flush_i, in_valid, in_last, fifo_full, fifo_empty, res_valid, out_ready,
    input  in_ready, fifo_push, fifo_pull, fifo_flush, res_ready, out_valid, out_sop, out_eop,
           out_beat_idx, cw_stored, err_overflow, err_framing, err_underflow, cw_in_cnt, cw_out_cnt
  );
  modport slave (
    input  flush_i, in_valid, in_last, fifo_full, fifo_empty, res_valid, out_ready,
    output in_ready, fifo_push, fifo_pull, fifo_flush, res_ready, out_valid, out_sop, out_eop,
           out_beat_idx, cw_stored, err_overflow, err_framing, err_underflow, cw_in_cnt, cw_out_cnt
  );
endinterface

// File: rtl/rs_cw_buffer_ctrl.sv
// rs_cw_buffer_ctrl: push/pull/flush control of the Forney codeword delay FIFO, one codeword per result.
// Optional codeword statistics counters under RS_CW_BUF_CTRL_STATS_EN.
module rs_cw_buffer_ctrl #(
  parameter int BEATS  = 34,
  parameter int MAX_CW = 4,
  parameter int BEAT_W = 6,
  parameter int CNT_W  = 3
) (
  input logic               clk_i,
  input logic               rst_ni,
  rs_cw_buffer_ctrl_if.slave bus
);
  typedef enum logic {IDLE, STREAM} state_t;
  localparam logic [BEAT_W-1:0] LAST   = BEAT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]  CW_MAX = CNT_W'(MAX_CW);
  state_t            state, state_d;
  logic [BEAT_W-1:0] wr_beat, rd_beat;
  logic [CNT_W-1:0]  cw;
  logic              err_o, err_f, err_u;
  logic              stream, wr_done, rd_done;
  assign stream           = state == STREAM;
  assign bus.in_ready     = rst_ni & ~bus.fifo_full & ~bus.flush_i & ~(wr_beat == '0 && cw == CW_MAX);
  assign bus.fifo_push    = bus.in_valid & bus.in_ready;
  assign bus.fifo_flush   = bus.flush_i | ~rst_ni;
  // Streaming never looks at fifo_empty: a whole codeword is known to be stored.
  assign bus.out_valid    = rst_ni & ~bus.flush_i & stream;
  assign bus.fifo_pull    = bus.out_valid & bus.out_ready;
  assign bus.res_ready    = rst_ni & ~bus.flush_i & ~stream & bus.res_valid & (cw != '0);
  assign bus.out_sop      = rst_ni & stream & (rd_beat == '0);
  assign bus.out_eop      = rst_ni & stream & (rd_beat == LAST);
  assign bus.out_beat_idx = rst_ni ? rd_beat : '0;
  assign bus.cw_stored    = cw;
  assign bus.err_overflow  = err_o;
  assign bus.err_framing   = err_f;
  assign bus.err_underflow = err_u;
  assign wr_done = bus.fifo_push & (wr_beat == LAST);
  assign rd_done = bus.fifo_pull & (rd_beat == LAST);
  always_comb begin
    state_d = state;
    state_d = stream ? (rd_done ? IDLE : STREAM) : (bus.res_ready ? STREAM : IDLE);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni || bus.flush_i) begin
      state   <= IDLE;
      wr_beat <= '0;
      rd_beat <= '0;
      cw      <= '0;
      err_o   <= 1'b0;
      err_f   <= 1'b0;
      err_u   <= 1'b0;
    end else begin
      state   <= state_d;
      wr_beat <= bus.fifo_push ? (wr_done ? '0 : wr_beat + 1'b1) : wr_beat;
      rd_beat <= bus.res_ready ? '0 : bus.fifo_pull ? (rd_done ? '0 : rd_beat + 1'b1) : rd_beat;
      cw      <= cw + CNT_W'(wr_done) - CNT_W'(rd_done);
      err_o   <= err_o | (bus.in_valid & ~bus.in_ready);
      err_f   <= err_f | (bus.fifo_push & (bus.in_last != (wr_beat == LAST)));
      err_u   <= err_u | (bus.fifo_pull & bus.fifo_empty);
    end
  end
`ifdef RS_CW_BUF_CTRL_STATS_EN
  logic [15:0] in_cnt, out_cnt;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      in_cnt  <= in_cnt + 16'(wr_done);
      out_cnt <= out_cnt + 16'(rd_done);
    end
  end
  assign bus.cw_in_cnt  = in_cnt;
  assign bus.cw_out_cnt = out_cnt;
`else
  assign bus.cw_in_cnt  = '0;
  assign bus.cw_out_cnt = '0;
`endif
endmodule
